// File: rtl/rw_stream_pkg.sv
// Shared types and defaults for the ReWire output packing path.
package rw_stream_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef logic [BYTE_W-1:0]   byte_t;
    typedef logic [2*BYTE_W-1:0] word_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } pack_state_t;

endpackage

// File: rtl/rw_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Occupancy is tracked in level, so full/empty never depend on pointer compare.
module rw_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop on a full FIFO frees the slot for a same-cycle push.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/rw_out_packer.sv
// Pairs the ReWire byte stream into 16-bit words (first byte low) and queues
// them behind a valid/ready interface with a sticky overflow flag.
module rw_out_packer
    import rw_stream_pkg::*;
#(
    parameter int unsigned DATA_W = BYTE_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    output logic [2*DATA_W-1:0]       out_data,
    input  logic                      out_ready,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    level
);

    pack_state_t         state_q, state_d;
    logic [DATA_W-1:0]   held_q, held_d;
    logic                overflow_q, overflow_d;
    logic                word_done;
    logic                fifo_push, fifo_pop;
    logic                fifo_full, fifo_empty;
    logic [2*DATA_W-1:0] word;

    assign word      = {in_data, held_q};
    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;
    assign fifo_pop  = out_ready && !fifo_empty && !flush;
    assign fifo_push = word_done && (!fifo_full || fifo_pop);

    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        overflow_d = overflow_q;
        word_done  = 1'b0;
        if (flush) begin
            state_d = EMPTY;
            held_d  = '0;
        end else if (in_valid) begin
            unique case (state_q)
                EMPTY: begin
                    held_d  = in_data;
                    state_d = HELD;
                end
                HELD: begin
                    word_done = 1'b1;
                    state_d   = EMPTY;
                    if (fifo_full && !fifo_pop) begin
                        overflow_d = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= EMPTY;
            held_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            overflow_q <= overflow_d;
        end
    end

    rw_sync_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (word),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule

// File: tb/tb_rw_out_packer.sv
// Directed bench for rw_out_packer with hand-computed expectations.
module tb_rw_out_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        overflow;
    logic [2:0]  level;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    rw_out_packer #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overflow  (overflow),
        .level     (level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level",     32'(level),     32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_out_data",  32'(out_data),  32'h0);

        // Basic pack; 0xAA seen during reset must not pair with 0x34
        rst = 1'b1;
        in_valid = 1'b1; in_data = 8'h34; tick();
        check("pack_half_valid", 32'(out_valid), 32'd0);
        in_data = 8'h12; tick();
        in_valid = 1'b0;
        check("pack_valid", 32'(out_valid), 32'd1);
        check("pack_data",  32'(out_data),  32'h1234);
        check("pack_level", 32'(level),     32'd1);

        // Bubbles and drain
        out_ready = 1'b1;
        tick();
        check("drain0_level", 32'(level), 32'd0);
        put(8'h01);
        tick();
        tick();
        check("empty_pop_level", 32'(level), 32'd0);
        put(8'h02);
        check("bub_w0_valid", 32'(out_valid), 32'd1);
        check("bub_w0_data",  32'(out_data),  32'h0201);
        put(8'h03);
        check("bub_pop_level", 32'(level), 32'd0);
        put(8'h04);
        check("bub_w1_data",  32'(out_data), 32'h0403);
        check("bub_w1_level", 32'(level),    32'd1);
        tick();
        check("bub_end_level", 32'(level),     32'd0);
        check("bub_end_valid", 32'(out_valid), 32'd0);

        // Fill to full with 0x1100..0x1103
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(8'(i));
            put(8'h11);
            check("fill_level", 32'(level), 32'(i + 1));
        end
        check("fill_overflow", 32'(overflow), 32'd0);
        check("fill_head",     32'(out_data), 32'h1100);

        // Full, pop coincides with the completing byte of 0xBEEF
        put(8'hEF);
        out_ready = 1'b1;
        put(8'hBE);
        out_ready = 1'b0;
        check("fullpp_level",    32'(level),    32'd4);
        check("fullpp_overflow", 32'(overflow), 32'd0);
        check("fullpp_head",     32'(out_data), 32'h1101);

        // Full, no pop: 0x2200 is dropped
        put(8'h00);
        put(8'h22);
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_level", 32'(level),    32'd4);
        check("ovf_head",  32'(out_data), 32'h1101);

        out_ready = 1'b1;
        check("rd_1101", 32'(out_data), 32'h1101); tick();
        check("rd_1102", 32'(out_data), 32'h1102); tick();
        check("rd_1103", 32'(out_data), 32'h1103); tick();
        check("rd_beef", 32'(out_data), 32'hBEEF); tick();
        check("rd_empty_valid", 32'(out_valid), 32'd0);
        check("rd_empty_level", 32'(level),     32'd0);

        // Flush with byte held and two words queued
        out_ready = 1'b0;
        put(8'h0B); put(8'h0A); put(8'h0D); put(8'h0C);
        check("pre_flush_level", 32'(level), 32'd2);
        put(8'h55);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h66; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush_level",    32'(level),     32'd0);
        check("flush_valid",    32'(out_valid), 32'd0);
        check("flush_overflow", 32'(overflow),  32'd1);
        put(8'h77);
        put(8'h88);
        check("post_flush_data",  32'(out_data), 32'h8877);
        check("post_flush_level", 32'(level),    32'd1);

        // Reset mid-word drops the held byte and clears overflow
        put(8'h99);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_level",    32'(level),     32'd0);
        check("midrst_valid",    32'(out_valid), 32'd0);
        check("midrst_overflow", 32'(overflow),  32'd0);
        put(8'h01);
        check("midrst_half_valid", 32'(out_valid), 32'd0);
        put(8'h02);
        check("midrst_data", 32'(out_data), 32'h0201);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
